// File: rtl/pcie_dma_pkg.sv
// Shared PCIe DMA definitions: TLP fmt/type codes and RX engine state encodings.
package pcie_dma_pkg;

  localparam logic [6:0] FT_MRD32 = 7'h00;
  localparam logic [6:0] FT_MRD64 = 7'h20;
  localparam logic [6:0] FT_MWR32 = 7'h40;
  localparam logic [6:0] FT_MWR64 = 7'h60;
  localparam logic [6:0] FT_IORD  = 7'h02;
  localparam logic [6:0] FT_IOWR  = 7'h42;
  localparam logic [6:0] FT_CPLD  = 7'h4A;
  localparam logic [6:0] FT_CPL   = 7'h0A;

  typedef enum logic [2:0] {
    RX_RST             = 3'd0,
    RX_MEM_RD32_DW1DW2 = 3'd1,
    RX_MEM_WR32_DW1DW2 = 3'd2,
    RX_MEM_RD64_DW1DW2 = 3'd3,
    RX_MEM_WR64_DW1DW2 = 3'd4,
    RX_MEM_WR64_DW3    = 3'd5,
    RX_DRAIN           = 3'd6,
    RX_WAIT            = 3'd7
  } rx_state_e;

  // DW-aligned byte address from a DW index
  function automatic logic [12:0] dw_byte_addr(input logic [10:0] dw);
    return {dw, 2'b00};
  endfunction

endpackage

// File: rtl/pcie_io_rx_engine.sv
// Single-DW PCIe memory (and optionally IO) request receiver on a 64-bit AXI-stream.
// Optional feature: define PCIE_IO_RX_IO_TLP_EN to accept IORd/IOWr TLPs.
module pcie_io_rx_engine
  import pcie_dma_pkg::*;
#(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8
) (
  input  logic                    i_nrst,
  input  logic                    i_clk,
  input  logic [C_DATA_WIDTH-1:0] i_m_axis_rx_tdata,
  input  logic [KEEP_WIDTH-1:0]   i_m_axis_rx_tkeep,
  input  logic                    i_m_axis_rx_tlast,
  input  logic                    i_m_axis_rx_tvalid,
  output logic                    o_m_axis_rx_tready,
  output logic                    o_req_compl,
  output logic                    o_req_compl_wd,
  output logic [2:0]              o_req_tc,
  output logic                    o_req_td,
  output logic                    o_req_ep,
  output logic [1:0]              o_req_attr,
  output logic [9:0]              o_req_len,
  output logic [15:0]             o_req_rid,
  output logic [7:0]              o_req_tag,
  output logic [7:0]              o_req_be,
  output logic [12:0]             o_req_addr,
  input  logic                    i_compl_done,
  output logic [10:0]             o_wr_addr,
  output logic [7:0]              o_wr_be,
  output logic [31:0]             o_wr_data,
  output logic                    o_wr_en,
  input  logic                    i_wr_busy
);

  rx_state_e   state_q, state_d, next_s;
  logic        tready_q, tready_d;
  logic        compl_q, compl_d, compl_wd_q, compl_wd_d;
  logic [2:0]  tc_q, tc_d;
  logic        td_q, td_d, ep_q, ep_d;
  logic [1:0]  attr_q, attr_d;
  logic [9:0]  len_q, len_d;
  logic [15:0] rid_q, rid_d;
  logic [7:0]  tag_q, tag_d, be_q, be_d;
  logic [12:0] addr_q, addr_d;
  logic [10:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_be_q, wr_be_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        wr_en_q, wr_en_d;
  logic        wait_cpl_q, wait_cpl_d, wait_wr_q, wait_wr_d;
  logic        is_io_q, is_io_d, done_seen_q, done_seen_d;
  logic        beat_s, exit_s;
  logic        unused_s;

  assign unused_s = ^{i_m_axis_rx_tkeep, i_m_axis_rx_tdata[23], i_m_axis_rx_tdata[19:16],
                      i_m_axis_rx_tdata[11:10], i_m_axis_rx_tdata[1:0]};

  assign beat_s = i_m_axis_rx_tvalid & tready_q;
  // Write must have been issued at least one cycle ago; completion may already be latched.
  assign exit_s = (~wait_cpl_q | i_compl_done | done_seen_q) &
                  (~wait_wr_q | (~wr_en_q & ~i_wr_busy));

  always_comb begin
    state_d     = state_q;
    next_s      = RX_DRAIN;
    compl_d     = 1'b0;
    compl_wd_d  = compl_wd_q;
    tc_d        = tc_q;
    td_d        = td_q;
    ep_d        = ep_q;
    attr_d      = attr_q;
    len_d       = len_q;
    rid_d       = rid_q;
    tag_d       = tag_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wr_addr_d   = wr_addr_q;
    wr_be_d     = wr_be_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    wait_cpl_d  = wait_cpl_q;
    wait_wr_d   = wait_wr_q;
    is_io_d     = is_io_q;
    done_seen_d = done_seen_q;
    case (state_q)
      RX_RST: begin
        if (beat_s) begin
          is_io_d = 1'b0;
          case (i_m_axis_rx_tdata[30:24])
            FT_MRD32: next_s = RX_MEM_RD32_DW1DW2;
            FT_MRD64: next_s = RX_MEM_RD64_DW1DW2;
            FT_MWR32: next_s = RX_MEM_WR32_DW1DW2;
            FT_MWR64: next_s = RX_MEM_WR64_DW1DW2;
`ifdef PCIE_IO_RX_IO_TLP_EN
            FT_IORD:  next_s = RX_MEM_RD32_DW1DW2;
            FT_IOWR: begin
              next_s  = RX_MEM_WR32_DW1DW2;
              is_io_d = 1'b1;
            end
`endif
            default:  next_s = RX_DRAIN;
          endcase
          if (i_m_axis_rx_tdata[9:0] != 10'd1) begin
            next_s = RX_DRAIN;
          end else begin
            next_s = next_s;
          end
          // Header fields only change for requests we will actually serve
          if (next_s != RX_DRAIN) begin
            tc_d   = i_m_axis_rx_tdata[22:20];
            td_d   = i_m_axis_rx_tdata[15];
            ep_d   = i_m_axis_rx_tdata[14];
            attr_d = i_m_axis_rx_tdata[13:12];
            len_d  = i_m_axis_rx_tdata[9:0];
            rid_d  = i_m_axis_rx_tdata[63:48];
            tag_d  = i_m_axis_rx_tdata[47:40];
            be_d   = i_m_axis_rx_tdata[39:32];
          end else begin
            is_io_d = 1'b0;
          end
          state_d = i_m_axis_rx_tlast ? RX_RST : next_s;
        end else begin
          state_d = RX_RST;
        end
      end
      RX_MEM_RD32_DW1DW2, RX_MEM_RD64_DW1DW2: begin
        if (beat_s) begin
          if (state_q == RX_MEM_RD32_DW1DW2) begin
            addr_d = dw_byte_addr(i_m_axis_rx_tdata[12:2]);
          end else begin
            addr_d = dw_byte_addr(i_m_axis_rx_tdata[44:34]);
          end
          compl_d     = 1'b1;
          compl_wd_d  = 1'b1;
          wait_cpl_d  = 1'b1;
          wait_wr_d   = 1'b0;
          done_seen_d = i_compl_done;
          state_d     = RX_WAIT;
        end else begin
          state_d = state_q;
        end
      end
      RX_MEM_WR32_DW1DW2, RX_MEM_WR64_DW3: begin
        if (beat_s) begin
          if (state_q == RX_MEM_WR32_DW1DW2) begin
            addr_d    = dw_byte_addr(i_m_axis_rx_tdata[12:2]);
            wr_addr_d = i_m_axis_rx_tdata[12:2];
            wr_data_d = i_m_axis_rx_tdata[63:32];
          end else begin
            wr_data_d = i_m_axis_rx_tdata[31:0];
          end
          wr_be_d     = {4'h0, be_q[3:0]};
          wr_en_d     = 1'b1;
          wait_wr_d   = 1'b1;
          wait_cpl_d  = is_io_q;
          done_seen_d = is_io_q & i_compl_done;
          if (is_io_q) begin
            compl_d    = 1'b1;
            compl_wd_d = 1'b0;
          end else begin
            compl_d = 1'b0;
          end
          state_d = RX_WAIT;
        end else begin
          state_d = state_q;
        end
      end
      RX_MEM_WR64_DW1DW2: begin
        if (beat_s && i_m_axis_rx_tlast) begin
          state_d = RX_RST;
        end else if (beat_s) begin
          addr_d    = dw_byte_addr(i_m_axis_rx_tdata[44:34]);
          wr_addr_d = i_m_axis_rx_tdata[44:34];
          state_d   = RX_MEM_WR64_DW3;
        end else begin
          state_d = state_q;
        end
      end
      RX_DRAIN: begin
        if (beat_s && i_m_axis_rx_tlast) begin
          state_d = RX_RST;
        end else begin
          state_d = RX_DRAIN;
        end
      end
      RX_WAIT: begin
        if (exit_s) begin
          state_d     = RX_RST;
          done_seen_d = 1'b0;
        end else begin
          done_seen_d = done_seen_q | i_compl_done;
        end
      end
      default: state_d = RX_RST;
    endcase
    tready_d = (state_d != RX_WAIT);
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q     <= RX_RST;
      tready_q    <= 1'b0;
      compl_q     <= 1'b0;
      compl_wd_q  <= 1'b0;
      tc_q        <= 3'd0;
      td_q        <= 1'b0;
      ep_q        <= 1'b0;
      attr_q      <= 2'd0;
      len_q       <= 10'd0;
      rid_q       <= 16'd0;
      tag_q       <= 8'd0;
      be_q        <= 8'd0;
      addr_q      <= 13'd0;
      wr_addr_q   <= 11'd0;
      wr_be_q     <= 8'd0;
      wr_data_q   <= 32'd0;
      wr_en_q     <= 1'b0;
      wait_cpl_q  <= 1'b0;
      wait_wr_q   <= 1'b0;
      is_io_q     <= 1'b0;
      done_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tready_q    <= tready_d;
      compl_q     <= compl_d;
      compl_wd_q  <= compl_wd_d;
      tc_q        <= tc_d;
      td_q        <= td_d;
      ep_q        <= ep_d;
      attr_q      <= attr_d;
      len_q       <= len_d;
      rid_q       <= rid_d;
      tag_q       <= tag_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wr_addr_q   <= wr_addr_d;
      wr_be_q     <= wr_be_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      wait_cpl_q  <= wait_cpl_d;
      wait_wr_q   <= wait_wr_d;
      is_io_q     <= is_io_d;
      done_seen_q <= done_seen_d;
    end
  end

  assign o_m_axis_rx_tready = tready_q;
  assign o_req_compl        = compl_q;
  assign o_req_compl_wd     = compl_wd_q;
  assign o_req_tc           = tc_q;
  assign o_req_td           = td_q;
  assign o_req_ep           = ep_q;
  assign o_req_attr         = attr_q;
  assign o_req_len          = len_q;
  assign o_req_rid          = rid_q;
  assign o_req_tag          = tag_q;
  assign o_req_be           = be_q;
  assign o_req_addr         = addr_q;
  assign o_wr_addr          = wr_addr_q;
  assign o_wr_be            = wr_be_q;
  assign o_wr_data          = wr_data_q;
  assign o_wr_en            = wr_en_q;

endmodule

// File: tb/tb_pcie_io_rx_engine.sv
// Directed self-checking bench for pcie_io_rx_engine (IO TLP checks follow PCIE_IO_RX_IO_TLP_EN).
module tb_pcie_io_rx_engine;

  logic        i_nrst, i_clk;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast, tvalid, tready;
  logic        req_compl, req_compl_wd, req_td, req_ep;
  logic [2:0]  req_tc;
  logic [1:0]  req_attr;
  logic [9:0]  req_len;
  logic [15:0] req_rid;
  logic [7:0]  req_tag, req_be;
  logic [12:0] req_addr;
  logic        compl_done;
  logic [10:0] wr_addr;
  logic [7:0]  wr_be;
  logic [31:0] wr_data;
  logic        wr_en, wr_busy;

  int total = 0;
  int bad   = 0;
  int wr_cnt  = 0;
  int cpl_cnt = 0;

  pcie_io_rx_engine dut (
    .i_nrst(i_nrst), .i_clk(i_clk),
    .i_m_axis_rx_tdata(tdata), .i_m_axis_rx_tkeep(tkeep),
    .i_m_axis_rx_tlast(tlast), .i_m_axis_rx_tvalid(tvalid),
    .o_m_axis_rx_tready(tready),
    .o_req_compl(req_compl), .o_req_compl_wd(req_compl_wd),
    .o_req_tc(req_tc), .o_req_td(req_td), .o_req_ep(req_ep),
    .o_req_attr(req_attr), .o_req_len(req_len), .o_req_rid(req_rid),
    .o_req_tag(req_tag), .o_req_be(req_be), .o_req_addr(req_addr),
    .i_compl_done(compl_done),
    .o_wr_addr(wr_addr), .o_wr_be(wr_be), .o_wr_data(wr_data),
    .o_wr_en(wr_en), .i_wr_busy(wr_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (wr_en === 1'b1) wr_cnt++;
    if (req_compl === 1'b1) cpl_cnt++;
  end

  function automatic logic [63:0] hdr(input logic [6:0] fmt, input logic [2:0] tc,
                                      input logic [3:0] tea, input logic [15:0] rid,
                                      input logic [7:0] tag, input logic [7:0] be,
                                      input logic [9:0] len);
    return {rid, tag, be, 1'b0, fmt, 1'b0, tc, 4'h0, tea, 2'b00, len};
  endfunction

  task automatic send_beat(input logic [63:0] d, input logic last);
    int n;
    n = 0;
    while (tready !== 1'b1 && n < 50) begin
      @(posedge i_clk); #1; n++;
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL beat_ready_timeout got tready=%b exp 1", tready);
    end
    tdata = d; tlast = last; tvalid = 1'b1;
    @(posedge i_clk); #1;
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (tready !== 1'b1 && n < 50) begin
      @(posedge i_clk); #1; n++;
    end
    total++;
    if (tready !== 1'b1) begin
      bad++; $display("FAIL %s_ready_timeout got=%b exp=1", name, tready);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge i_clk);
    #1;
    total++; if (tready !== 1'b0) begin bad++; $display("FAIL rst_tready got=%b exp=0", tready); end
    total++; if ({req_compl, req_compl_wd, req_addr, req_rid, req_be, wr_en, wr_addr, wr_data} !== '0) begin
      bad++; $display("FAIL rst_outputs got nonzero exp=0"); end
    i_nrst = 1'b1;
    #1;
    total++; if (tready !== 1'b0) begin bad++; $display("FAIL rst_tready_release got=%b exp=0", tready); end
    @(posedge i_clk); #1;
    total++; if (tready !== 1'b1) begin bad++; $display("FAIL rst_tready_first_clk got=%b exp=1", tready); end
  endtask

  task automatic test_mrd32();
    send_beat(hdr(7'h00, 3'h5, 4'hA, 16'h0100, 8'h05, 8'h0F, 10'd1), 1'b0);
    send_beat({32'h0, 32'h0000_0104}, 1'b1);
    total++; if (req_compl !== 1'b1) begin bad++; $display("FAIL mrd32_compl got=%b exp=1", req_compl); end
    total++; if (req_addr !== 13'h104) begin bad++; $display("FAIL mrd32_addr got=%h exp=104", req_addr); end
    total++; if (req_be !== 8'h0F) begin bad++; $display("FAIL mrd32_be got=%h exp=0f", req_be); end
    total++; if ({req_rid, req_tag} !== {16'h0100, 8'h05}) begin
      bad++; $display("FAIL mrd32_rid_tag got=%h exp=010005", {req_rid, req_tag}); end
    total++; if ({req_tc, req_td, req_ep, req_attr, req_len} !== {3'h5, 1'b1, 1'b0, 2'b10, 10'd1}) begin
      bad++; $display("FAIL mrd32_fields got=%h exp=%h", {req_tc, req_td, req_ep, req_attr, req_len},
                      {3'h5, 1'b1, 1'b0, 2'b10, 10'd1}); end
    total++; if (req_compl_wd !== 1'b1) begin bad++; $display("FAIL mrd32_wd got=%b exp=1", req_compl_wd); end
    total++; if (tready !== 1'b0) begin bad++; $display("FAIL mrd32_tready_wait got=%b exp=0", tready); end
    repeat (3) @(posedge i_clk);
    #1;
    total++; if (req_compl !== 1'b0) begin bad++; $display("FAIL mrd32_compl_pulse got=%b exp=0", req_compl); end
    total++; if (tready !== 1'b0) begin bad++; $display("FAIL mrd32_tready_held got=%b exp=0", tready); end
    total++; if ({req_addr, req_tag} !== {13'h104, 8'h05}) begin
      bad++; $display("FAIL mrd32_stable got=%h exp=%h", {req_addr, req_tag}, {13'h104, 8'h05}); end
    compl_done = 1'b1;
    @(posedge i_clk); #1;
    compl_done = 1'b0;
    total++; if (tready !== 1'b1) begin bad++; $display("FAIL mrd32_exit got=%b exp=1", tready); end
  endtask

  task automatic test_mwr32();
    int w0;
    w0 = wr_cnt;
    wr_busy = 1'b1;
    send_beat(hdr(7'h40, 3'h0, 4'h0, 16'h0100, 8'h06, 8'h03, 10'd1), 1'b0);
    send_beat({32'hDEADBEEF, 32'h0000_0020}, 1'b1);
    total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL mwr32_en got=%b exp=1", wr_en); end
    total++; if ({wr_addr, wr_be, wr_data} !== {11'h008, 8'h03, 32'hDEADBEEF}) begin
      bad++; $display("FAIL mwr32_port got=%h exp=%h", {wr_addr, wr_be, wr_data}, {11'h008, 8'h03, 32'hDEADBEEF}); end
    total++; if (req_compl !== 1'b0) begin bad++; $display("FAIL mwr32_no_compl got=%b exp=0", req_compl); end
    repeat (3) @(posedge i_clk);
    #1;
    total++; if (tready !== 1'b0) begin bad++; $display("FAIL mwr32_busy_hold got=%b exp=0", tready); end
    wr_busy = 1'b0;
    @(posedge i_clk); #1;
    total++; if (tready !== 1'b1) begin bad++; $display("FAIL mwr32_exit got=%b exp=1", tready); end
    total++; if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL mwr32_count got=%0d exp=1", wr_cnt - w0); end
  endtask

  task automatic test_mwr64();
    send_beat(hdr(7'h60, 3'h0, 4'h0, 16'h0100, 8'h07, 8'h0F, 10'd1), 1'b0);
    send_beat({32'h0000_1FFC, 32'h0}, 1'b0);
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL mwr64_early_en got=%b exp=0", wr_en); end
    send_beat({32'h0, 32'h12345678}, 1'b1);
    total++; if ({wr_en, wr_addr, wr_be, wr_data} !== {1'b1, 11'h7FF, 8'h0F, 32'h12345678}) begin
      bad++; $display("FAIL mwr64_port got=%h exp=%h", {wr_en, wr_addr, wr_be, wr_data},
                      {1'b1, 11'h7FF, 8'h0F, 32'h12345678}); end
    @(posedge i_clk); #1;
    total++; if (tready !== 1'b0) begin bad++; $display("FAIL mwr64_min_wait got=%b exp=0", tready); end
    @(posedge i_clk); #1;
    total++; if (tready !== 1'b1) begin bad++; $display("FAIL mwr64_exit got=%b exp=1", tready); end
  endtask

  task automatic test_sticky_done();
    send_beat(hdr(7'h20, 3'h0, 4'h0, 16'h0200, 8'h09, 8'hF1, 10'd1), 1'b0);
    compl_done = 1'b1;
    send_beat({32'h0000_0ABC, 32'h0}, 1'b1);
    compl_done = 1'b0;
    total++; if ({req_compl, req_addr, req_be, req_rid} !== {1'b1, 13'h0ABC, 8'hF1, 16'h0200}) begin
      bad++; $display("FAIL mrd64_req got=%h exp=%h", {req_compl, req_addr, req_be, req_rid},
                      {1'b1, 13'h0ABC, 8'hF1, 16'h0200}); end
    total++; if (tready !== 1'b0) begin bad++; $display("FAIL mrd64_tready got=%b exp=0", tready); end
    @(posedge i_clk); #1;
    total++; if (tready !== 1'b1) begin bad++; $display("FAIL sticky_done_exit got=%b exp=1", tready); end
  endtask

  task automatic test_drain();
    int w0, c0;
    w0 = wr_cnt; c0 = cpl_cnt;
    send_beat(hdr(7'h30, 3'h0, 4'h0, 16'h0300, 8'h01, 8'h0F, 10'd1), 1'b0);
    send_beat({32'h0, 32'h0000_0040}, 1'b0);
    send_beat({32'h0, 32'h0000_0040}, 1'b1);
    send_beat(hdr(7'h40, 3'h0, 4'h0, 16'h0300, 8'h02, 8'h0F, 10'd2), 1'b0);
    send_beat({32'h11111111, 32'h0000_0040}, 1'b0);
    send_beat({32'h22222222, 32'h0}, 1'b1);
    send_beat(hdr(7'h60, 3'h0, 4'h0, 16'h0300, 8'h03, 8'h0F, 10'd1), 1'b0);
    send_beat({32'h0000_0080, 32'h0}, 1'b1);
    send_beat(hdr(7'h30, 3'h0, 4'h0, 16'h0300, 8'h04, 8'h0F, 10'd1), 1'b1);
    repeat (2) @(posedge i_clk);
    #1;
    total++; if (wr_cnt - w0 !== 0 || cpl_cnt - c0 !== 0) begin
      bad++; $display("FAIL drain_pulses got wr=%0d cpl=%0d exp=0", wr_cnt - w0, cpl_cnt - c0); end
    total++; if (tready !== 1'b1) begin bad++; $display("FAIL drain_tready got=%b exp=1", tready); end
    send_beat(hdr(7'h00, 3'h0, 4'h0, 16'h0400, 8'h0B, 8'h0F, 10'd1), 1'b0);
    send_beat({32'h0, 32'h0000_0104}, 1'b1);
    total++; if ({req_compl, req_addr, req_tag} !== {1'b1, 13'h104, 8'h0B}) begin
      bad++; $display("FAIL after_drain_mrd32 got=%h exp=%h", {req_compl, req_addr, req_tag}, {1'b1, 13'h104, 8'h0B}); end
    compl_done = 1'b1;
    @(posedge i_clk); #1;
    compl_done = 1'b0;
    wait_ready("after_drain");
  endtask

  task automatic test_reset_mid_tlp();
    int w0;
    w0 = wr_cnt;
    send_beat(hdr(7'h40, 3'h0, 4'h0, 16'h0500, 8'h0C, 8'h0F, 10'd1), 1'b0);
    i_nrst = 1'b0;
    #1;
    total++; if (tready !== 1'b0) begin bad++; $display("FAIL midrst_tready got=%b exp=0", tready); end
    repeat (2) @(posedge i_clk);
    #1;
    i_nrst = 1'b1;
    @(posedge i_clk); #1;
    total++; if (tready !== 1'b1) begin bad++; $display("FAIL midrst_release got=%b exp=1", tready); end
    repeat (5) @(posedge i_clk);
    #1;
    total++; if (wr_cnt - w0 !== 0) begin bad++; $display("FAIL midrst_no_wr got=%0d exp=0", wr_cnt - w0); end
  endtask

  task automatic test_io();
    int w0, c0;
    w0 = wr_cnt; c0 = cpl_cnt;
    send_beat(hdr(7'h42, 3'h0, 4'h0, 16'h0600, 8'h0D, 8'h0F, 10'd1), 1'b0);
    send_beat({32'hCAFE0001, 32'h0000_0008}, 1'b1);
`ifdef PCIE_IO_RX_IO_TLP_EN
    total++; if ({wr_en, wr_addr, req_compl, req_compl_wd} !== {1'b1, 11'h002, 1'b1, 1'b0}) begin
      bad++; $display("FAIL iowr_resp got=%h exp=%h", {wr_en, wr_addr, req_compl, req_compl_wd},
                      {1'b1, 11'h002, 1'b1, 1'b0}); end
    repeat (3) @(posedge i_clk);
    #1;
    total++; if (tready !== 1'b0) begin bad++; $display("FAIL iowr_wait_cpl got=%b exp=0", tready); end
    compl_done = 1'b1;
    @(posedge i_clk); #1;
    compl_done = 1'b0;
    wait_ready("iowr");
`else
    repeat (3) @(posedge i_clk);
    #1;
    total++; if (wr_cnt - w0 !== 0 || cpl_cnt - c0 !== 0) begin
      bad++; $display("FAIL iowr_ignored got wr=%0d cpl=%0d exp=0", wr_cnt - w0, cpl_cnt - c0); end
    total++; if (tready !== 1'b1) begin bad++; $display("FAIL iowr_tready got=%b exp=1", tready); end
`endif
  endtask

  initial begin
    i_nrst = 1'b0; tdata = 64'd0; tkeep = 8'hFF; tlast = 1'b0; tvalid = 1'b0;
    compl_done = 1'b0; wr_busy = 1'b0;
    test_reset();
    test_mrd32();
    test_mwr32();
    test_mwr64();
    test_sticky_done();
    test_drain();
    test_io();
    test_reset_mid_tlp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
